// File: rtl/data_cache_pkg.sv
// Shared types, width constants and line access helpers for the data cache.
package data_cache_pkg;

  localparam int DC_LINE_W   = 128;  // bits per cache line
  localparam int DC_WORD_W   = 32;   // widest core access
  localparam int DC_ADDR_W   = 32;   // byte address width
  localparam int DC_OFFSET_W = 4;    // byte offset inside a line

  typedef enum logic {
    SIZE_BYTE = 1'b0,
    SIZE_WORD = 1'b1
  } access_size_t;

  typedef struct packed {
    logic [DC_ADDR_W-1:0] addr;
    access_size_t         size;
    logic                 is_store;
    logic [DC_WORD_W-1:0] data;
  } dcache_request_t;

  typedef struct packed {
    logic [DC_ADDR_W-1:0] addr;
    logic                 is_store;
    logic [DC_LINE_W-1:0] data;
  } memory_request_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVICT = 2'd1,
    FILL  = 2'd2
  } dcache_state_t;

  // Little-endian read; a WORD uses the word lane, a BYTE is zero-extended.
  function automatic logic [DC_WORD_W-1:0] load_extract(
    input logic [DC_LINE_W-1:0]   line,
    input logic [DC_OFFSET_W-1:0] offset,
    input access_size_t           size
  );
    if (size == SIZE_WORD) return line[{offset[3:2], 5'b00000} +: DC_WORD_W];
    return {24'h000000, line[{offset, 3'b000} +: 8]};
  endfunction

  // Overlay store data on a line at the given offset.
  function automatic logic [DC_LINE_W-1:0] store_merge(
    input logic [DC_LINE_W-1:0]   line,
    input logic [DC_OFFSET_W-1:0] offset,
    input access_size_t           size,
    input logic [DC_WORD_W-1:0]   data
  );
    logic [DC_LINE_W-1:0] merged;
    merged = line;
    if (size == SIZE_WORD) merged[{offset[3:2], 5'b00000} +: DC_WORD_W] = data;
    else                   merged[{offset, 3'b000} +: 8] = data[7:0];
    return merged;
  endfunction

  // Line-aligned read request for the line holding addr.
  function automatic memory_request_t fill_request(input logic [DC_ADDR_W-1:0] addr);
    memory_request_t r;
    r.addr     = {addr[DC_ADDR_W-1:DC_OFFSET_W], {DC_OFFSET_W{1'b0}}};
    r.is_store = 1'b0;
    r.data     = '0;
    return r;
  endfunction

endpackage

// File: rtl/data_cache_lru.sv
// Age-based LRU tracker: age 0 is most recent, age NUM_LINES-1 is the victim.
module dcache_lru #(
  parameter  int NUM_LINES = 4,
  localparam int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             touch,
  input  logic [IDX_W-1:0] touch_idx,
  output logic [IDX_W-1:0] lru_idx
);

  logic [IDX_W-1:0] age_q [NUM_LINES];

  // Touched line becomes youngest; lines younger than it age by one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINES; i++) age_q[i] <= IDX_W'(i);
    end else if (touch) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        if (IDX_W'(i) == touch_idx)          age_q[i] <= '0;
        else if (age_q[i] < age_q[touch_idx]) age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end

  // The oldest line is the replacement candidate.
  always_comb begin
    lru_idx = '0;
    for (int i = 0; i < NUM_LINES; i++)
      if (age_q[i] == IDX_W'(NUM_LINES - 1)) lru_idx = IDX_W'(i);
  end

endmodule

// File: rtl/data_cache.sv
// Fully associative write-back, write-allocate data cache with LRU replacement.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int DCACHE_LINE_WIDTH   = 128,
  parameter int DCACHE_NUM_LINES    = 4,
  parameter int DCACHE_MAX_ACC_SIZE = 32,
  parameter int ADDR_WIDTH          = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  output logic                           dcache_ready,
  output logic                           xcpt_address_fault,
  input  logic                           req_valid,
  input  dcache_request_t                req_info,
  output logic                           rsp_valid,
  output logic [DCACHE_MAX_ACC_SIZE-1:0] rsp_data,
  output logic                           req_valid_miss,
  output memory_request_t                req_info_miss,
  input  logic [DCACHE_LINE_WIDTH-1:0]   rsp_data_miss,
  input  logic                           rsp_valid_miss
);

  localparam int IDX_W = $clog2(DCACHE_NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - DC_OFFSET_W;

  dcache_state_t                state_q;
  dcache_request_t              pend_q;
  logic [IDX_W-1:0]             victim_q;
  logic [DCACHE_NUM_LINES-1:0]  valid_q, dirty_q;
  logic [DCACHE_LINE_WIDTH-1:0] line_q [DCACHE_NUM_LINES];
  logic [TAG_W-1:0]             tag_q  [DCACHE_NUM_LINES];

  logic                         hit, has_invalid, misaligned, accept;
  logic                         hit_access, fill_done;
  logic [IDX_W-1:0]             hit_idx, free_idx, lru_idx, victim_sel;
  logic                         wr_en;
  logic [IDX_W-1:0]             wr_idx;
  logic [DCACHE_LINE_WIDTH-1:0] wr_line;
  logic [TAG_W-1:0]             wr_tag;

  assign dcache_ready = (state_q == IDLE);
  assign accept       = req_valid && dcache_ready;
  assign misaligned   = (req_info.size == SIZE_WORD) && (req_info.addr[1:0] != 2'b00);
  assign hit_access   = accept && !misaligned && hit;
  assign fill_done    = (state_q == FILL) && rsp_valid_miss;
  assign victim_sel   = has_invalid ? free_idx : lru_idx;

  // Tag match for the incoming request and lowest-numbered free line.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    hit         = 1'b0;
    hit_idx     = '0;
    has_invalid = 1'b0;
    free_idx    = '0;
    for (int i = DCACHE_NUM_LINES - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == req_info.addr[ADDR_WIDTH-1:DC_OFFSET_W]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        has_invalid = 1'b1;
        free_idx    = IDX_W'(i);
      end
    end
  end

  // Line/tag write port: fill completion (with pending store merged) or store hit.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = hit_idx;
    wr_line = line_q[hit_idx];
    wr_tag  = tag_q[hit_idx];
    if (fill_done) begin
      wr_en   = 1'b1;
      wr_idx  = victim_q;
      wr_tag  = pend_q.addr[ADDR_WIDTH-1:DC_OFFSET_W];
      wr_line = pend_q.is_store
              ? store_merge(rsp_data_miss, pend_q.addr[3:0], pend_q.size, pend_q.data)
              : rsp_data_miss;
    end else if (hit_access && req_info.is_store) begin
      wr_en   = 1'b1;
      wr_line = store_merge(line_q[hit_idx], req_info.addr[3:0], req_info.size, req_info.data);
    end
  end

  // Line data and tag storage.
  // NOTE: data and tags are not reset; valid bits gate every use of them.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      line_q[wr_idx] <= wr_line;
      tag_q[wr_idx]  <= wr_tag;
    end
  end

  dcache_lru #(
    .NUM_LINES (DCACHE_NUM_LINES)
  ) u_lru (
    .clock     (clock),
    .reset     (reset),
    .touch     (hit_access || fill_done),
    .touch_idx (fill_done ? victim_q : hit_idx),
    .lru_idx   (lru_idx)
  );

  // Controller: hit service, victim write-back, line fill and registered outputs.
  // NOTE: non-blocking throughout, so every branch sees the pre-edge state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q            <= IDLE;
      pend_q             <= '0;
      victim_q           <= '0;
      valid_q            <= '0;
      dirty_q            <= '0;
      rsp_valid          <= 1'b0;
      rsp_data           <= '0;
      xcpt_address_fault <= 1'b0;
      req_valid_miss     <= 1'b0;
      req_info_miss      <= '0;
    end else begin
      rsp_valid          <= 1'b0;
      xcpt_address_fault <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (misaligned) begin
              xcpt_address_fault <= 1'b1;
            end else if (hit) begin
              rsp_valid <= 1'b1;
              if (req_info.is_store) dirty_q[hit_idx] <= 1'b1;
              else rsp_data <= load_extract(line_q[hit_idx], req_info.addr[3:0], req_info.size);
            end else begin
              pend_q         <= req_info;
              victim_q       <= victim_sel;
              req_valid_miss <= 1'b1;
              if (valid_q[victim_sel] && dirty_q[victim_sel]) begin
                state_q                <= EVICT;
                req_info_miss.addr     <= {tag_q[victim_sel], {DC_OFFSET_W{1'b0}}};
                req_info_miss.is_store <= 1'b1;
                req_info_miss.data     <= line_q[victim_sel];
              end else begin
                state_q       <= FILL;
                req_info_miss <= fill_request(req_info.addr);
              end
            end
          end
        end
        EVICT: begin
          if (rsp_valid_miss) begin
            dirty_q[victim_q] <= 1'b0;
            state_q           <= FILL;
            req_info_miss     <= fill_request(pend_q.addr);
          end
        end
        FILL: begin
          if (rsp_valid_miss) begin
            valid_q[victim_q] <= 1'b1;
            dirty_q[victim_q] <= pend_q.is_store;
            state_q           <= IDLE;
            req_valid_miss    <= 1'b0;
            req_info_miss     <= '0;
            rsp_valid         <= 1'b1;
            if (!pend_q.is_store)
              rsp_data <= load_extract(rsp_data_miss, pend_q.addr[3:0], pend_q.size);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache.
module tb_data_cache;
  import data_cache_pkg::*;

  logic            clock = 1'b0;
  logic            reset;
  logic            dcache_ready, xcpt_address_fault;
  logic            req_valid;
  dcache_request_t req_info;
  logic            rsp_valid;
  logic [31:0]     rsp_data;
  logic            req_valid_miss;
  memory_request_t req_info_miss;
  logic [127:0]    rsp_data_miss;
  logic            rsp_valid_miss;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] L1  = {32'h11223344, 32'h55667788, 32'h0BADF00D, 32'hDEADBEEF};
  localparam logic [127:0] L1M = {32'h11223344, 32'h55667788, 32'h12AB5678, 32'hDEADBEEF};

  data_cache dut (
    .clock              (clock),
    .reset              (reset),
    .dcache_ready       (dcache_ready),
    .xcpt_address_fault (xcpt_address_fault),
    .req_valid          (req_valid),
    .req_info           (req_info),
    .rsp_valid          (rsp_valid),
    .rsp_data           (rsp_data),
    .req_valid_miss     (req_valid_miss),
    .req_info_miss      (req_info_miss),
    .rsp_data_miss      (rsp_data_miss),
    .rsp_valid_miss     (rsp_valid_miss)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk_line(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  // Present one request for a single edge; returns at the following negedge.
  task automatic send(input logic [31:0] addr, input access_size_t size,
                      input logic is_store, input logic [31:0] data);
    req_valid         = 1'b1;
    req_info.addr     = addr;
    req_info.size     = size;
    req_info.is_store = is_store;
    req_info.data     = data;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_miss(input string tag);
    for (int n = 0; n < 20 && !req_valid_miss; n++) @(negedge clock);
    check(tag, req_valid_miss, 1'b1);
  endtask

  // One-cycle memory acknowledge carrying a line.
  task automatic mem_reply(input logic [127:0] line);
    rsp_data_miss  = line;
    rsp_valid_miss = 1'b1;
    @(negedge clock);
    rsp_valid_miss = 1'b0;
  endtask

  task automatic load_hit(input string tag, input logic [31:0] addr,
                          input access_size_t size, input logic [31:0] exp);
    send(addr, size, 1'b0, 32'h0);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    check({tag, "_rsp_data"}, rsp_data, exp);
    check({tag, "_no_mem"}, req_valid_miss, 1'b0);
  endtask

  task automatic load_miss(input string tag, input logic [31:0] addr,
                           input logic [127:0] line, input logic [31:0] exp);
    send(addr, SIZE_WORD, 1'b0, 32'h0);
    wait_miss({tag, "_miss"});
    check({tag, "_fill_addr"}, req_info_miss.addr, {addr[31:4], 4'h0});
    check({tag, "_fill_store"}, req_info_miss.is_store, 1'b0);
    mem_reply(line);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    check({tag, "_rsp_data"}, rsp_data, exp);
    check({tag, "_ready"}, dcache_ready, 1'b1);
  endtask

  initial begin
    int pulses;
    reset          = 1'b1;
    req_valid      = 1'b0;
    req_info       = '0;
    rsp_data_miss  = '0;
    rsp_valid_miss = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset state
    check("rst_ready", dcache_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_xcpt", xcpt_address_fault, 1'b0);
    check("rst_req_valid_miss", req_valid_miss, 1'b0);
    check("rst_req_info_miss", req_info_miss, '0);

    // Cold miss on 0x100 goes straight to FILL
    send(32'h100, SIZE_WORD, 1'b0, 32'h0);
    check("m100_ready_low", dcache_ready, 1'b0);
    check("m100_req", req_valid_miss, 1'b1);
    check("m100_addr", req_info_miss.addr, 32'h100);
    check("m100_store", req_info_miss.is_store, 1'b0);
    check("m100_no_rsp", rsp_valid, 1'b0);
    mem_reply(L1);
    check("m100_rsp_valid", rsp_valid, 1'b1);
    check("m100_rsp_data", rsp_data, 32'hDEADBEEF);
    check("m100_ready", dcache_ready, 1'b1);
    check("m100_req_drop", req_valid_miss, 1'b0);
    @(negedge clock);
    check("m100_rsp_pulse", rsp_valid, 1'b0);

    // Store hits, then loads of the modified line
    send(32'h104, SIZE_WORD, 1'b1, 32'h12345678);
    check("st104_rsp_valid", rsp_valid, 1'b1);
    check("st104_ready", dcache_ready, 1'b1);
    check("st104_no_mem", req_valid_miss, 1'b0);
    load_hit("ld105_byte", 32'h105, SIZE_BYTE, 32'h00000056);
    send(32'h106, SIZE_BYTE, 1'b1, 32'hFFFFFFAB);
    check("st106_rsp_valid", rsp_valid, 1'b1);
    load_hit("ld104_word", 32'h104, SIZE_WORD, 32'h12AB5678);
    load_hit("ld10f_byte", 32'h10F, SIZE_BYTE, 32'h00000011);

    // Misaligned WORD load faults
    send(32'h102, SIZE_WORD, 1'b0, 32'h0);
    check("x102_xcpt", xcpt_address_fault, 1'b1);
    check("x102_no_rsp", rsp_valid, 1'b0);
    check("x102_no_mem", req_valid_miss, 1'b0);
    @(negedge clock);
    check("x102_xcpt_pulse", xcpt_address_fault, 1'b0);
    check("x102_no_mem_later", req_valid_miss, 1'b0);

    // Fill the remaining three lines; 0x100 becomes least recent
    load_miss("m200", 32'h200, mk_line(32'h20000000), 32'h20000000);
    load_miss("m300", 32'h304, mk_line(32'h30000000), 32'h30000001);
    load_miss("m400", 32'h40C, mk_line(32'h40000000), 32'h40000003);

    // Miss on 0x500 evicts dirty 0x100, then fills 0x500
    send(32'h508, SIZE_WORD, 1'b0, 32'h0);
    check("ev_req", req_valid_miss, 1'b1);
    check("ev_store", req_info_miss.is_store, 1'b1);
    check("ev_addr", req_info_miss.addr, 32'h100);
    check("ev_data", req_info_miss.data, L1M);
    mem_reply(128'h0);
    check("ev_fill_req", req_valid_miss, 1'b1);
    check("ev_fill_store", req_info_miss.is_store, 1'b0);
    check("ev_fill_addr", req_info_miss.addr, 32'h500);
    check("ev_no_rsp", rsp_valid, 1'b0);
    mem_reply(mk_line(32'h50000000));
    check("ev_rsp_valid", rsp_valid, 1'b1);
    check("ev_rsp_data", rsp_data, 32'h50000002);

    // 0x100 was evicted: it misses again and every victim now is clean
    load_miss("m100b", 32'h104, L1M, 32'h12AB5678);

    // Request held with changing contents during a miss: only 0x600 completes
    pulses = 0;
    req_valid         = 1'b1;
    req_info.addr     = 32'h600;
    req_info.size     = SIZE_WORD;
    req_info.is_store = 1'b0;
    req_info.data     = 32'h0;
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      check("hold_ready", dcache_ready, 1'b0);
      check("hold_miss_addr", req_info_miss.addr, 32'h600);
      if (rsp_valid) pulses++;
      req_info.addr     = 32'h400 + 32'(i * 4);
      req_info.is_store = 1'b1;
      req_info.data     = 32'hFFFFFFFF;
      @(negedge clock);
    end
    rsp_data_miss  = mk_line(32'h60000000);
    rsp_valid_miss = 1'b1;
    req_valid      = 1'b0;
    @(negedge clock);
    rsp_valid_miss = 1'b0;
    check("hold_rsp_data", rsp_data, 32'h60000000);
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) pulses++;
      @(negedge clock);
    end
    check("hold_one_pulse", pulses, 1);
    load_hit("hold_ld400", 32'h400, SIZE_WORD, 32'h40000000);

    // Reset during FILL aborts the memory request
    send(32'h800, SIZE_WORD, 1'b0, 32'h0);
    check("rf_req", req_valid_miss, 1'b1);
    reset = 1'b1;
    #1;
    check("rf_req_drop", req_valid_miss, 1'b0);
    check("rf_ready", dcache_ready, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    load_miss("rf_m800", 32'h800, mk_line(32'h80000000), 32'h80000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
